// File: rtl/dm_read_cache.sv
// Direct-mapped read-only cache between the CPU read port and SDRAM.
// Hits return a word from on-chip storage; misses refill a whole line from word 0 upward.
module dm_read_cache #(
  parameter int unsigned NUM_LINES      = 256,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  output logic        cpu_ready,
  output logic [31:0] cpu_data,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned WA_W   = 30;
  localparam int unsigned LINE_W = WA_W - OFF_W;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    RESPOND
  } state_t;

  state_t            state;
  logic [WA_W-1:0]   req_waddr;
  logic [OFF_W-1:0]  wc;
  logic [NUM_LINES-1:0] valid;

  logic [31:0]       data_mem [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];

  logic [TAG_W-1:0]  req_tag_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [OFF_W-1:0]  req_off_c;
  logic [LINE_W-1:0] req_line_c;
  logic              hit_c;
  logic              fill_we_c;
  logic              unused_addr_bits;

  // Byte-lane bits of the CPU address carry no information for word reads.
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign req_line_c = req_waddr[WA_W-1:OFF_W];
  assign req_tag_c  = req_waddr[WA_W-1 -: TAG_W];
  assign req_idx_c  = req_waddr[OFF_W +: IDX_W];
  assign req_off_c  = req_waddr[OFF_W-1:0];
  assign hit_c      = valid[req_idx_c] && (tag_mem[req_idx_c] == req_tag_c);
  assign fill_we_c  = !rst && (state == FILL_WAIT) && mem_data_valid;

  // Line storage: data and tags are unreset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      data_mem[req_idx_c][wc] <= mem_data;
      if (wc == LAST_WORD) begin
        tag_mem[req_idx_c] <= req_tag_c;
      end
    end
  end

  // Control FSM with registered CPU/SDRAM outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_waddr  <= '0;
      wc         <= '0;
      valid      <= '0;
      cpu_ready  <= 1'b0;
      cpu_data   <= 32'd0;
      mem_read   <= 1'b0;
      mem_addr   <= 32'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      cpu_ready <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_read) begin
            req_waddr <= cpu_addr[31:2];
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_c) begin
            cpu_data  <= data_mem[req_idx_c][req_off_c];
            cpu_ready <= 1'b1;
            if (hit_count != 32'hFFFF_FFFF) begin
              hit_count <= hit_count + 32'd1;
            end
            state <= IDLE;
          end else begin
            if (miss_count != 32'hFFFF_FFFF) begin
              miss_count <= miss_count + 32'd1;
            end
            valid[req_idx_c] <= 1'b0;
            wc               <= '0;
            // Strobe is registered here so it is high for the whole FILL_REQ cycle.
            mem_read <= 1'b1;
            mem_addr <= {req_line_c, OFF_W'(0), 2'b00};
            state    <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (mem_data_valid) begin
            if (wc == LAST_WORD) begin
              valid[req_idx_c] <= 1'b1;
              state            <= RESPOND;
            end else begin
              wc       <= wc + OFF_W'(1);
              mem_read <= 1'b1;
              mem_addr <= {req_line_c, wc + OFF_W'(1), 2'b00};
              state    <= FILL_REQ;
            end
          end
        end
        RESPOND: begin
          cpu_data  <= data_mem[req_idx_c][req_off_c];
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_read_cache.sv
// Directed bench for dm_read_cache with a small SDRAM model whose word i holds i+1.
module tb_dm_read_cache;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_data_valid;
  logic [31:0] mem_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt = 0;
  int rdy_cnt = 0;
  logic [31:0] addr_log[$];
  logic        stall_w2 = 1'b0;

  logic        p_act;
  int          p_cnt;
  logic [31:0] p_addr;

  dm_read_cache dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: answers on the edge that samples mem_read, optionally late on word 2.
  always @(posedge clk) begin
    mem_data_valid <= 1'b0;
    if (rst) begin
      p_act <= 1'b0;
    end else if (mem_read && !(stall_w2 && mem_addr[3:2] == 2'd2)) begin
      mem_data_valid <= 1'b1;
      mem_data       <= (mem_addr >> 2) + 32'd1;
    end else if (mem_read) begin
      p_act  <= 1'b1;
      p_cnt  <= 2;
      p_addr <= mem_addr;
    end else if (p_act) begin
      if (p_cnt == 0) begin
        mem_data_valid <= 1'b1;
        mem_data       <= (p_addr >> 2) + 32'd1;
        p_act          <= 1'b0;
      end else begin
        p_cnt <= p_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      addr_log.push_back(mem_addr);
    end
    if (cpu_ready) rdy_cnt <= rdy_cnt + 1;
  end

  // Caller must be mid-cycle; returns just after the sampling edge.
  task automatic start_req(input logic [31:0] a);
    cpu_addr = a;
    cpu_read = 1'b1;
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    t0 = cyc;
  endtask

  // Returns at the negedge inside the cpu_ready cycle.
  task automatic wait_ready(output logic [31:0] d, output int lat);
    lat = -1;
    d = 32'd0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = cyc - t0;
        d = cpu_data;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: no cpu_ready within 200 cycles");
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_read = 1'b0;
    cpu_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (cpu_ready !== 1'b0) begin n_cmp++; n_err++; $display("FAIL rst_ready: got %b expected 0", cpu_ready); end else n_cmp++;
    if (cpu_data !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rst_data: got 0x%08h expected 0", cpu_data); end else n_cmp++;
    if (mem_read !== 1'b0) begin n_cmp++; n_err++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end else n_cmp++;
    if (mem_addr !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rst_mem_addr: got 0x%08h expected 0", mem_addr); end else n_cmp++;
    if (hit_count !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rst_hits: got %0d expected 0", hit_count); end else n_cmp++;
    if (miss_count !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rst_misses: got %0d expected 0", miss_count); end else n_cmp++;
  endtask

  task automatic test_cold_miss();
    logic [31:0] d;
    int lat;
    logic [31:0] exp_a[4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
    addr_log.delete();
    @(negedge clk);
    start_req(32'h0000_0010);
    wait_ready(d, lat);
    if (lat !== 10) begin n_cmp++; n_err++; $display("FAIL cold_latency: got %0d expected 10", lat); end else n_cmp++;
    if (d !== 32'h5) begin n_cmp++; n_err++; $display("FAIL cold_data: got 0x%08h expected 0x5", d); end else n_cmp++;
    if (addr_log.size() !== 4) begin n_cmp++; n_err++; $display("FAIL cold_reads: got %0d expected 4", addr_log.size()); end else n_cmp++;
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_cmp++;
      if (addr_log[i] !== exp_a[i]) begin
        n_err++;
        $display("FAIL cold_addr%0d: got 0x%08h expected 0x%08h", i, addr_log[i], exp_a[i]);
      end
    end
    if (miss_count !== 32'd1) begin n_cmp++; n_err++; $display("FAIL cold_misses: got %0d expected 1", miss_count); end else n_cmp++;
    if (hit_count !== 32'd0) begin n_cmp++; n_err++; $display("FAIL cold_hits: got %0d expected 0", hit_count); end else n_cmp++;
  endtask

  task automatic test_hit();
    logic [31:0] d;
    int lat;
    int r0;
    @(negedge clk);
    r0 = rd_cnt;
    start_req(32'h0000_0014);
    wait_ready(d, lat);
    if (lat !== 1) begin n_cmp++; n_err++; $display("FAIL hit_latency: got %0d expected 1", lat); end else n_cmp++;
    if (d !== 32'h6) begin n_cmp++; n_err++; $display("FAIL hit_data: got 0x%08h expected 0x6", d); end else n_cmp++;
    if (rd_cnt - r0 !== 0) begin n_cmp++; n_err++; $display("FAIL hit_no_read: got %0d reads expected 0", rd_cnt - r0); end else n_cmp++;
    if (hit_count !== 32'd1) begin n_cmp++; n_err++; $display("FAIL hit_count: got %0d expected 1", hit_count); end else n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    start_req(32'h0000_0018);
    wait_ready(d, lat);
    if (lat !== 1 || d !== 32'h7) begin n_cmp++; n_err++; $display("FAIL b2b_first: got lat %0d data 0x%08h expected 1 0x7", lat, d); end else n_cmp++;
    // Request offered during the cpu_ready cycle is sampled at the edge ending it.
    start_req(32'h0000_001C);
    wait_ready(d, lat);
    if (lat !== 1 || d !== 32'h8) begin n_cmp++; n_err++; $display("FAIL b2b_second: got lat %0d data 0x%08h expected 1 0x8", lat, d); end else n_cmp++;
    if (hit_count !== 32'd3) begin n_cmp++; n_err++; $display("FAIL b2b_hits: got %0d expected 3", hit_count); end else n_cmp++;
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    start_req(32'h0000_1010);
    wait_ready(d, lat);
    if (lat !== 10 || d !== 32'h405) begin n_cmp++; n_err++; $display("FAIL conflict_evict: got lat %0d data 0x%08h expected 10 0x405", lat, d); end else n_cmp++;
    @(negedge clk);
    start_req(32'h0000_0010);
    wait_ready(d, lat);
    if (lat !== 10 || d !== 32'h5) begin n_cmp++; n_err++; $display("FAIL conflict_back: got lat %0d data 0x%08h expected 10 0x5", lat, d); end else n_cmp++;
    if (miss_count !== 32'd3) begin n_cmp++; n_err++; $display("FAIL conflict_misses: got %0d expected 3", miss_count); end else n_cmp++;
  endtask

  task automatic test_valid_stall();
    logic [31:0] d;
    int lat;
    int r0;
    stall_w2 = 1'b1;
    @(negedge clk);
    r0 = rd_cnt;
    start_req(32'h0000_1018);
    wait_ready(d, lat);
    stall_w2 = 1'b0;
    if (lat !== 13) begin n_cmp++; n_err++; $display("FAIL stall_latency: got %0d expected 13", lat); end else n_cmp++;
    if (d !== 32'h407) begin n_cmp++; n_err++; $display("FAIL stall_data: got 0x%08h expected 0x407", d); end else n_cmp++;
    if (rd_cnt - r0 !== 4) begin n_cmp++; n_err++; $display("FAIL stall_reads: got %0d expected 4", rd_cnt - r0); end else n_cmp++;
    if (miss_count !== 32'd4) begin n_cmp++; n_err++; $display("FAIL stall_misses: got %0d expected 4", miss_count); end else n_cmp++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d;
    int lat;
    int k0;
    @(negedge clk);
    k0 = rdy_cnt;
    start_req(32'h0000_2020);
    repeat (3) @(negedge clk);
    cpu_addr = 32'h0000_0014;
    cpu_read = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0;
    wait_ready(d, lat);
    if (lat !== 10 || d !== 32'h809) begin n_cmp++; n_err++; $display("FAIL busy_resp: got lat %0d data 0x%08h expected 10 0x809", lat, d); end else n_cmp++;
    repeat (6) @(negedge clk);
    if (rdy_cnt - k0 !== 1) begin n_cmp++; n_err++; $display("FAIL busy_pulses: got %0d expected 1", rdy_cnt - k0); end else n_cmp++;
    if (hit_count !== 32'd3) begin n_cmp++; n_err++; $display("FAIL busy_hits: got %0d expected 3", hit_count); end else n_cmp++;
    if (miss_count !== 32'd5) begin n_cmp++; n_err++; $display("FAIL busy_misses: got %0d expected 5", miss_count); end else n_cmp++;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d;
    int lat;
    int k0;
    logic [31:0] exp_a[4] = '{32'h3030, 32'h3034, 32'h3038, 32'h303C};
    @(negedge clk);
    k0 = rdy_cnt;
    start_req(32'h0000_3030);
    for (int i = 0; i < 50 && (cyc - t0) < 5; i++) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    if (rdy_cnt - k0 !== 0) begin n_cmp++; n_err++; $display("FAIL rmf_no_ready: got %0d pulses expected 0", rdy_cnt - k0); end else n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rmf_cleared: got hits %0d misses %0d expected 0 0", hit_count, miss_count); end else n_cmp++;
    addr_log.delete();
    start_req(32'h0000_3030);
    wait_ready(d, lat);
    if (lat !== 10 || d !== 32'hC0D) begin n_cmp++; n_err++; $display("FAIL rmf_refill: got lat %0d data 0x%08h expected 10 0xc0d", lat, d); end else n_cmp++;
    if (addr_log.size() !== 4) begin n_cmp++; n_err++; $display("FAIL rmf_reads: got %0d expected 4", addr_log.size()); end else n_cmp++;
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_cmp++;
      if (addr_log[i] !== exp_a[i]) begin
        n_err++;
        $display("FAIL rmf_addr%0d: got 0x%08h expected 0x%08h", i, addr_log[i], exp_a[i]);
      end
    end
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin n_cmp++; n_err++; $display("FAIL rmf_counts: got hits %0d misses %0d expected 0 1", hit_count, miss_count); end else n_cmp++;
    // Lines filled before reset must have lost their valid bits.
    @(negedge clk);
    start_req(32'h0000_0010);
    wait_ready(d, lat);
    if (lat !== 10 || d !== 32'h5) begin n_cmp++; n_err++; $display("FAIL rmf_old_line: got lat %0d data 0x%08h expected 10 0x5", lat, d); end else n_cmp++;
    chk("rmf_misses", miss_count, 32'd2);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_valid_stall();
    test_busy_ignore();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
